// File: rtl/seq_det_multi_pkg.sv
// Shared types and default constants for the multi-channel
// serial pattern detector.
package seq_det_multi_pkg;

   typedef enum logic {
      ST_OK    = 1'b0,
      ST_ERROR = 1'b1
   } chan_state_e;

   localparam int unsigned DEF_CH      = 4;
   localparam int unsigned DEF_PAT_LEN = 2;
   localparam logic [1:0]  DEF_PATTERN = 2'b10;
   localparam bit          DEF_OVERLAP = 1'b1;
   localparam int unsigned DEF_MAX_RUN = 3;
   localparam int unsigned DEF_CW      = 8;

   // MAX_RUN is at most 255, so the run counter never needs more
   localparam int unsigned RUN_W = 8;

endpackage

// File: rtl/seq_det_chan.sv
// One detector channel: pattern history, run-length guard,
// OK/ERROR state and saturating match counter.
module seq_det_chan
   import seq_det_multi_pkg::*;
#(
   parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN,
   parameter bit                   OVERLAP = DEF_OVERLAP,
   parameter int unsigned          MAX_RUN = DEF_MAX_RUN,
   parameter int unsigned          CW      = DEF_CW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   input  logic          i_clr,
   input  logic          i_a,
   output logic          o_y,
   output logic          o_err,
   output logic [CW-1:0] o_cnt
);

   localparam int unsigned FW = $clog2(PAT_LEN);
   localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN - 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

   chan_state_e          r_state;
   chan_state_e          w_state_nx;
   logic [PAT_LEN-2:0]   r_hist;
   logic [PAT_LEN-2:0]   w_hist_nx;
   logic [FW-1:0]        r_fill;
   logic [FW-1:0]        w_fill_nx;
   logic [RUN_W-1:0]     r_run;
   logic [RUN_W-1:0]     w_run_nx;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nx;
   logic [PAT_LEN-1:0]   w_win;
   logic                 w_live;
   logic                 w_run_err;
   logic                 w_match;

   // Oldest history bit sits at the MSB, the live input at the LSB
   assign w_win     = {r_hist, i_a};
   assign w_live    = i_en & ~i_clr & (r_state == ST_OK);
   assign w_run_err = w_live & i_a & (r_run == RUN_MAX);
   assign w_match   = w_live & ~w_run_err & (r_fill == FILL_FULL)
                    & (w_win == PATTERN);

   assign o_y   = w_match;
   assign o_err = (r_state == ST_ERROR);
   assign o_cnt = r_cnt;

   // State register for FSM, history, run and counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_OK;
         r_hist  <= '0;
         r_fill  <= '0;
         r_run   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_hist  <= w_hist_nx;
         r_fill  <= w_fill_nx;
         r_run   <= w_run_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Next-state: clear wins, run error freezes, else shift and count
   always_comb begin
      w_state_nx = r_state;
      w_hist_nx  = r_hist;
      w_fill_nx  = r_fill;
      w_run_nx   = r_run;
      w_cnt_nx   = r_cnt;
      if (i_clr) begin
         w_state_nx = ST_OK;
         w_hist_nx  = '0;
         w_fill_nx  = '0;
         w_run_nx   = '0;
         w_cnt_nx   = '0;
      end else if (w_run_err) begin
         w_state_nx = ST_ERROR;
      end else if (w_live) begin
         w_run_nx = i_a ? (r_run + RUN_W'(1)) : '0;
         if (w_match && !OVERLAP) begin
            w_fill_nx = '0;
         end else begin
            w_hist_nx = w_win[PAT_LEN-2:0];
            if (r_fill != FILL_FULL)
               w_fill_nx = r_fill + FW'(1);
         end
         if (w_match && (r_cnt != '1))
            w_cnt_nx = r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seq_det_multi.sv
// Multi-channel serial pattern detector: CH independent
// seq_det_chan copies with packed count bus.
module seq_det_multi
   import seq_det_multi_pkg::*;
#(
   parameter int unsigned          CH      = DEF_CH,
   parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN,
   parameter bit                   OVERLAP = DEF_OVERLAP,
   parameter int unsigned          MAX_RUN = DEF_MAX_RUN,
   parameter int unsigned          CW      = DEF_CW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [CH-1:0]    a,
   output logic [CH-1:0]    y,
   output logic [CH-1:0]    err,
   output logic [CH*CW-1:0] cnt
);

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      seq_det_chan #(
         .PAT_LEN (PAT_LEN),
         .PATTERN (PATTERN),
         .OVERLAP (OVERLAP),
         .MAX_RUN (MAX_RUN),
         .CW      (CW)
      ) u_chan (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_en    (en),
         .i_clr   (clr),
         .i_a     (a[gi]),
         .o_y     (y[gi]),
         .o_err   (err[gi]),
         .o_cnt   (cnt[gi*CW +: CW])
      );
   end

endmodule

// File: doc/seq_det_multi.md
SEQ_DET_MULTI -- requirements
Module: seq_det_multi

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (1..16).
REQ-002 Parameter PAT_LEN, default 2, pattern length in bits (2..8).
REQ-003 Parameter PATTERN, default 2'b10, PAT_LEN-bit target pattern, MSB is the oldest bit.
REQ-004 Parameter OVERLAP, default 1; 1 = overlapping matches, 0 = history flushed after a match.
REQ-005 Parameter MAX_RUN, default 3, longest legal run of consecutive 1s per channel (1..255).
REQ-006 Parameter CW, default 8, per-channel match counter width.
REQ-007 clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 en  input  1  sample enable; when 0, no state changes and y is 0.
REQ-010 clr  input  1  synchronous clear of all channel state, error flags and counters.
REQ-011 a  input  CH  serial data, one bit per channel.
REQ-012 y  output  CH  Mealy match indication per channel, combinational from state and a.
REQ-013 err  output  CH  registered per-channel run-length error flag.
REQ-014 cnt  output  CH*CW  per-channel saturating match count; channel i occupies bits [i*CW +: CW].

Function
REQ-015 Each channel keeps a history of its last PAT_LEN-1 sampled bits plus a fill count of valid history bits (0..PAT_LEN-1).
REQ-016 y[i] is 1 when en=1, err[i]=0, the fill count equals PAT_LEN-1, clr=0, {history, a[i]} equals PATTERN, and the run-error condition in REQ-020 is not firing in the same cycle.
REQ-017 y[i] goes high in the same cycle as the final pattern bit (zero-cycle Mealy latency), with no registered delay.
REQ-018 On each enabled edge with err[i]=0, a[i] shifts into the history and the fill count increments, saturating at PAT_LEN-1.
REQ-019 OVERLAP=0 with y[i]=1: on that edge the history fill count resets to 0, and a[i] is discarded.
REQ-020 Run counter: on an enabled edge, a[i]=1 increments the run and a[i]=0 clears it; a[i]=1 with run==MAX_RUN sets err[i] on that edge and suppresses y[i] in that cycle.
REQ-021 Per-channel FSM has states OK and ERROR; the only OK->ERROR transition is REQ-020, and ERROR->OK occurs only on clr or reset.
REQ-022 In ERROR, history, fill count, run and cnt are frozen, and y[i]=0.
REQ-023 cnt[i] increments on every edge where y[i]=1 and saturates at 2^CW-1 without wrapping.
REQ-024 clr=1 takes priority over en: on that edge, history, fill count, run, err and cnt are all zeroed, and y is 0 during the clr cycle.
REQ-025 Channels are fully independent; simultaneous matches or errors on several channels are all honoured in the same cycle.

Reset
REQ-026 rst_n=0 asynchronously forces every channel to OK with history=0, fill count=0, run=0 and cnt=0, so err=0 and y=0.
REQ-027 Asserting rst_n mid-pattern discards partial history; after release, a match needs PAT_LEN fresh enabled samples.

Structure
REQ-028 A shared package holds the FSM state typedef (OK, ERROR) and the default parameter constants.
REQ-029 One sub-module, seq_det_chan, implements a single channel; the top module instantiates CH copies using a generate loop and has no other logic apart from bus packing.

Verification
REQ-030 Defaults, reset then en=1, a[0] sequence 0,0,1,0 -> y[0]=1 only during the cycle with the final 0, and cnt[0]=1 afterwards.
REQ-031 a[0] sequence 1,1,1,1 (MAX_RUN=3) -> err[0]=1 after the 4th edge, y[0] stays 0, and a later 0 input produces no match and no cnt change.
REQ-032 Pattern 3'b101: with OVERLAP=1, input 1,0,1,0,1 -> 2 matches; with OVERLAP=0, the same input -> 1 match.
REQ-033 CW=2, 5 separate 1,0 pairs -> cnt[0] saturates at 3.
REQ-034 en=0 between a 1 and a 0 -> no shift and y=0; history is held, and when en returns to 1, applying 0 gives y=1.
REQ-035 clr during err=1 on channel 2, with a simultaneous match on channel 1 -> all err, cnt and y cleared; rst_n pulsed mid-pattern -> next match needs a full fresh pattern.
